// File: rtl/rifl_rx_pkg.sv
// Shared types and defaults for the RIFL receive-side frame alignment logic.
package rifl_rx_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  localparam int unsigned LOCK_GOOD_DEF    = 8;
  localparam int unsigned UNLOCK_BAD_DEF   = 4;
  localparam int unsigned BLANK_FRAMES_DEF = 2;

  // Width of a beat-phase index; at least one bit even for single-beat frames.
  function automatic int unsigned PHASE_W(input int unsigned ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/rx_slip_phase_ctr.sv
// Beat-phase counter with one-beat slip execution and start-of-frame generation.
module rx_slip_phase_ctr #(
  parameter int unsigned RATIO   = 4,
  parameter int unsigned PHASE_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic               slip_req,
  output logic               slip_now_c,
  output logic               data_sof,
  output logic [PHASE_W-1:0] frame_phase
);

  logic slip_pending;

  // A pending slip consumes the next valid beat by holding the phase.
  assign slip_now_c = din_valid && slip_pending;
  assign data_sof   = din_valid && (frame_phase == '0) && !slip_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_phase  <= '0;
      slip_pending <= 1'b0;
    end else begin
      // Requests arriving while one is pending merge into that single slip.
      if (slip_now_c) begin
        slip_pending <= 1'b0;
      end else if (slip_req) begin
        slip_pending <= 1'b1;
      end

      if (din_valid && !slip_pending) begin
        if ((RATIO <= 1) || (frame_phase == PHASE_W'(RATIO - 1))) begin
          frame_phase <= '0;
        end else begin
          frame_phase <= frame_phase + PHASE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rx_frame_sync.sv
// Frame-alignment controller: hunts for, verifies and holds frame lock from
// per-frame CRC verdicts, slipping one beat whenever alignment is wrong.
module rx_frame_sync
  import rifl_rx_pkg::*;
#(
  parameter int unsigned RATIO        = 4,
  parameter int unsigned LOCK_GOOD    = LOCK_GOOD_DEF,
  parameter int unsigned UNLOCK_BAD   = UNLOCK_BAD_DEF,
  parameter int unsigned BLANK_FRAMES = BLANK_FRAMES_DEF,
  parameter int unsigned SLIP_CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        din_valid,
  input  logic                        crc_valid,
  input  logic                        crc_good,
  output logic                        data_sof,
  output logic [PHASE_W(RATIO)-1:0]   frame_phase,
  output logic                        locked,
  output logic                        slip_pulse,
  output logic [SLIP_CNT_W-1:0]       slip_count,
  output logic                        crc_gate
);

  localparam int unsigned PW      = PHASE_W(RATIO);
  localparam int unsigned GOOD_W  = (LOCK_GOOD <= 1) ? 1 : $clog2(LOCK_GOOD + 1);
  localparam int unsigned BAD_W   = (UNLOCK_BAD <= 1) ? 1 : $clog2(UNLOCK_BAD + 1);
  localparam int unsigned BLANK_W = (BLANK_FRAMES <= 1) ? 1 : $clog2(BLANK_FRAMES + 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_FRAMES);

  sync_state_t        state, state_nxt;
  logic [GOOD_W-1:0]  good_cnt, good_nxt;
  logic [BAD_W-1:0]   bad_cnt, bad_nxt;
  logic [BLANK_W-1:0] blank_cnt, blank_nxt;
  logic               slip_req_c;
  logic               slip_now_c;
  logic               crc_eval_c;

  rx_slip_phase_ctr #(
    .RATIO   (RATIO),
    .PHASE_W (PW)
  ) u_phase (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .slip_req    (slip_req_c),
    .slip_now_c  (slip_now_c),
    .data_sof    (data_sof),
    .frame_phase (frame_phase)
  );

  assign crc_gate = crc_valid && crc_good && locked;

  // Verdicts for frames already in the CRC pipeline at slip time are discarded;
  // one arriving on the slip beat itself is charged to the new window.
  always_comb begin
    blank_nxt  = blank_cnt;
    crc_eval_c = crc_valid && (blank_cnt == '0) && !(slip_now_c && (BLANK_FRAMES != 0));
    if (slip_now_c) begin
      if (crc_valid && (BLANK_FRAMES != 0)) begin
        blank_nxt = BLANK_LOAD - BLANK_W'(1);
      end else begin
        blank_nxt = BLANK_LOAD;
      end
    end else if (crc_valid && (blank_cnt != '0)) begin
      blank_nxt = blank_cnt - BLANK_W'(1);
    end
  end

  // Lock FSM: next state, counter updates and slip requests.
  always_comb begin
    state_nxt  = state;
    good_nxt   = good_cnt;
    bad_nxt    = bad_cnt;
    slip_req_c = 1'b0;
    if (crc_eval_c) begin
      unique case (state)
        HUNT: begin
          if (crc_good) begin
            if (LOCK_GOOD <= 1) begin
              state_nxt = LOCKED;
            end else begin
              state_nxt = VERIFY;
              good_nxt  = GOOD_W'(1);
            end
          end else begin
            slip_req_c = 1'b1;
          end
        end
        VERIFY: begin
          if (crc_good) begin
            if (good_cnt == GOOD_W'(LOCK_GOOD - 1)) begin
              state_nxt = LOCKED;
              good_nxt  = '0;
            end else begin
              good_nxt = good_cnt + GOOD_W'(1);
            end
          end else begin
            state_nxt  = HUNT;
            good_nxt   = '0;
            slip_req_c = 1'b1;
          end
        end
        LOCKED: begin
          if (crc_good) begin
            bad_nxt = '0;
          end else if (bad_cnt == BAD_W'(UNLOCK_BAD - 1)) begin
            state_nxt  = HUNT;
            bad_nxt    = '0;
            slip_req_c = 1'b1;
          end else begin
            bad_nxt = bad_cnt + BAD_W'(1);
          end
        end
        default: begin
          state_nxt = HUNT;
          good_nxt  = '0;
          bad_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      blank_cnt  <= '0;
      locked     <= 1'b0;
      slip_pulse <= 1'b0;
      slip_count <= '0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_nxt;
      bad_cnt    <= bad_nxt;
      blank_cnt  <= blank_nxt;
      locked     <= (state_nxt == LOCKED);
      slip_pulse <= slip_now_c;
      if (slip_now_c && (slip_count != '1)) begin
        slip_count <= slip_count + SLIP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_sync.sv
// Directed self-checking bench for rx_frame_sync with default parameters.
module tb_rx_frame_sync;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic        crc_valid;
  logic        crc_good;
  logic        data_sof;
  logic [1:0]  frame_phase;
  logic        locked;
  logic        slip_pulse;
  logic [15:0] slip_count;
  logic        crc_gate;

  int checks;
  int failures;

  rx_frame_sync dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .crc_valid   (crc_valid),
    .crc_good    (crc_good),
    .data_sof    (data_sof),
    .frame_phase (frame_phase),
    .locked      (locked),
    .slip_pulse  (slip_pulse),
    .slip_count  (slip_count),
    .crc_gate    (crc_gate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic cyc(input logic r, input logic dv, input logic cv, input logic cg);
    @(negedge clk);
    rst       = r;
    din_valid = dv;
    crc_valid = cv;
    crc_good  = cg;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (frame_phase !== 2'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", frame_phase); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (slip_pulse !== 1'b0) begin failures++; $display("FAIL reset_slip_pulse got=%b exp=0", slip_pulse); end
    checks++; if (slip_count !== 16'd0) begin failures++; $display("FAIL reset_slip_count got=%0d exp=0", slip_count); end
    checks++; if (data_sof !== 1'b0) begin failures++; $display("FAIL reset_sof_idle got=%b exp=0", data_sof); end
  endtask

  task automatic test_phase();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (frame_phase !== 2'(k % 4)) begin failures++; $display("FAIL phase_beat%0d got=%0d exp=%0d", k, frame_phase, k % 4); end
      checks++; if (data_sof !== ((k % 4) == 0)) begin failures++; $display("FAIL sof_beat%0d got=%b exp=%b", k, data_sof, (k % 4) == 0); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL phase_locked_beat%0d got=%b exp=0", k, locked); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early_good%0d got=%b exp=0", i, locked); end
      checks++; if (crc_gate !== 1'b0) begin failures++; $display("FAIL gate_prelock_good%0d got=%b exp=0", i, crc_gate); end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_rise got=%b exp=1", locked); end
    checks++; if (crc_gate !== 1'b1) begin failures++; $display("FAIL gate_locked_good got=%b exp=1", crc_gate); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (crc_gate !== 1'b0) begin failures++; $display("FAIL gate_locked_bad got=%b exp=0", crc_gate); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_hold_one_bad got=%b exp=1", locked); end
    checks++; if (crc_gate !== 1'b0) begin failures++; $display("FAIL gate_no_valid got=%b exp=0", crc_gate); end
  endtask

  task automatic test_slip_blank();
    int          exp_ph [13] = '{0, 1, 2, 2, 3, 0, 1, 2, 3, 0, 1, 2, 2};
    int          exp_cnt[13] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
    logic [12:0] bad_mask  = 13'b0010011000010;
    logic [12:0] sof_mask  = 13'b0001000100001;
    logic [12:0] puls_mask = 13'b1000000001000;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      cyc(1'b0, 1'b1, bad_mask[k], 1'b0);
      checks++; if (frame_phase !== 2'(exp_ph[k])) begin failures++; $display("FAIL slip_phase_beat%0d got=%0d exp=%0d", k, frame_phase, exp_ph[k]); end
      checks++; if (data_sof !== sof_mask[k]) begin failures++; $display("FAIL slip_sof_beat%0d got=%b exp=%b", k, data_sof, sof_mask[k]); end
      checks++; if (slip_pulse !== puls_mask[k]) begin failures++; $display("FAIL slip_pulse_beat%0d got=%b exp=%b", k, slip_pulse, puls_mask[k]); end
      checks++; if (slip_count !== 16'(exp_cnt[k])) begin failures++; $display("FAIL slip_count_beat%0d got=%0d exp=%0d", k, slip_count, exp_cnt[k]); end
    end
  endtask

  task automatic test_unlock();
    logic [6:0] good_seq = 7'b0000100;
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b0, 1'b1, good_seq[i]);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL unlock_hold_step%0d got=%b exp=1", i, locked); end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL unlock_drop got=%b exp=0", locked); end
    checks++; if (slip_pulse !== 1'b0) begin failures++; $display("FAIL unlock_pulse_frozen got=%b exp=0", slip_pulse); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (data_sof !== 1'b0) begin failures++; $display("FAIL unlock_sof_on_slip got=%b exp=0", data_sof); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (slip_pulse !== 1'b1) begin failures++; $display("FAIL unlock_pulse got=%b exp=1", slip_pulse); end
    checks++; if (slip_count !== 16'd1) begin failures++; $display("FAIL unlock_count got=%0d exp=1", slip_count); end
    checks++; if (frame_phase !== 2'd0) begin failures++; $display("FAIL unlock_phase_held got=%0d exp=0", frame_phase); end
    checks++; if (data_sof !== 1'b1) begin failures++; $display("FAIL unlock_sof_after got=%b exp=1", data_sof); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (frame_phase !== 2'd1) begin failures++; $display("FAIL unlock_phase_adv got=%0d exp=1", frame_phase); end
    checks++; if (slip_pulse !== 1'b0) begin failures++; $display("FAIL unlock_pulse_single got=%b exp=0", slip_pulse); end
  endtask

  task automatic test_verify_fail();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (data_sof !== 1'b0) begin failures++; $display("FAIL verify_sof_on_slip got=%b exp=0", data_sof); end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (slip_pulse !== 1'b1) begin failures++; $display("FAIL verify_pulse got=%b exp=1", slip_pulse); end
    checks++; if (slip_count !== 16'd1) begin failures++; $display("FAIL verify_count got=%0d exp=1", slip_count); end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL verify_relock_early%0d got=%b exp=0", i, locked); end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL verify_relock got=%b exp=1", locked); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (slip_count !== 16'd1) begin failures++; $display("FAIL mid_pre_count got=%0d exp=1", slip_count); end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (frame_phase !== 2'd0) begin failures++; $display("FAIL mid_phase got=%0d exp=0", frame_phase); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL mid_locked got=%b exp=0", locked); end
    checks++; if (slip_count !== 16'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", slip_count); end
    checks++; if (data_sof !== 1'b1) begin failures++; $display("FAIL mid_sof got=%b exp=1", data_sof); end
    checks++; if (slip_pulse !== 1'b0) begin failures++; $display("FAIL mid_pulse got=%b exp=0", slip_pulse); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (frame_phase !== 2'd1) begin failures++; $display("FAIL mid_phase_adv got=%0d exp=1", frame_phase); end
    checks++; if (data_sof !== 1'b0) begin failures++; $display("FAIL mid_sof_beat1 got=%b exp=0", data_sof); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    din_valid = 1'b0;
    crc_valid = 1'b0;
    crc_good  = 1'b0;
    test_reset();
    test_phase();
    test_lock();
    test_slip_blank();
    test_unlock();
    test_verify_fail();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_frame_sync.md
Name: rx_frame_sync

Overview:
- Frame-alignment controller in front of the RX width converter.
- Tracks the beat phase of incoming DWIDTH-wide words within a FRAME_WIDTH frame and generates data_sof for the converter and CRC checker.
- Uses per-frame CRC verdicts to hunt for, confirm and hold frame lock, slipping one beat on misalignment.
- Reports lock status and slip activity to link management.

Parameters:
- RATIO, 4, beats per frame (FRAME_WIDTH/DWIDTH); power of two, 1..16.
- LOCK_GOOD, 8, consecutive good CRCs needed to declare lock.
- UNLOCK_BAD, 4, consecutive bad CRCs while locked that drop lock.
- BLANK_FRAMES, 2, CRC verdicts discarded after each slip (frames already in flight in the CRC pipeline).
- SLIP_CNT_W, 16, width of the saturating slip counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- din_valid  in  1  a deserialized beat is present this cycle
- crc_valid  in  1  one CRC verdict per frame, in frame order, arbitrary fixed latency
- crc_good  in  1  verdict value, qualified by crc_valid
- data_sof  out  1  combinational: din_valid && phase==0 && !slip_now
- frame_phase  out  max(1,$clog2(RATIO))  current beat index within frame
- locked  out  1  registered lock status
- slip_pulse  out  1  registered, one-cycle pulse per slip
- slip_count  out  SLIP_CNT_W  saturating count of slips since reset
- crc_gate  out  1  crc_valid && crc_good && locked; downstream valid qualifier

Behaviour:
- Reset values: phase 0, state HUNT, locked 0, slip_pulse 0, slip_count 0, good_cnt/bad_cnt/blank_cnt 0.
- Phase counter:
  - Advances (wrapping at RATIO-1 to 0) on each din_valid beat unless that beat is a slip beat.
  - A slip holds phase for exactly one din_valid beat, delaying the frame boundary by one beat.
- Slip request:
  - A slip request is registered and executed on the next din_valid beat.
  - slip_pulse asserts the cycle after execution.
  - On execution, blank_cnt loads BLANK_FRAMES.
  - slip_count increments, saturating at all-ones.
- Blanking: while blank_cnt>0, each crc_valid decrements blank_cnt and is otherwise ignored (no state or counter effect).
- FSM (evaluated on non-blanked crc_valid only):
  - HUNT: good -> VERIFY, good_cnt=1. Bad -> request slip, stay HUNT.
  - VERIFY: good -> good_cnt++. When good_cnt reaches LOCK_GOOD -> LOCKED, locked=1 next cycle. Bad -> request slip, good_cnt=0, HUNT.
  - LOCKED: good -> bad_cnt=0. Bad -> bad_cnt++. When bad_cnt reaches UNLOCK_BAD -> HUNT, locked=0, request slip, bad_cnt=0.
  - LOCK_GOOD==1: first good in HUNT goes directly to LOCKED.
- Simultaneous events:
  - crc_valid coinciding with the slip-execution beat is counted against the blank window just loaded, i.e. blank_cnt loads BLANK_FRAMES-1.
  - A new slip request while one is pending is merged; only one slip executes.
- RATIO==1: phase is constant 0. Slips are counted and pulsed, but data_sof is still suppressed on the slip beat.
- din_valid low: phase, slip execution and data_sof all freeze; CRC verdicts are still processed.
- Reset mid-operation: all state returns to the reset values on the next clock edge. data_sof is gated by the reset phase immediately after.
- Latency:
  - data_sof is zero-latency from din_valid.
  - locked and slip_pulse are 1 cycle from the deciding crc_valid / slip beat.

Decomposition:
- Shared package rifl_rx_pkg holds:
  - sync_state_t enum {HUNT, VERIFY, LOCKED}
  - PHASE_W function (max(1,$clog2(RATIO)))
  - Default LOCK_GOOD, UNLOCK_BAD and BLANK_FRAMES constants
- One sub-module, rx_slip_phase_ctr, contains the phase counter, pending-slip register, slip execution and data_sof generation.
- The FSM, the good/bad/blank counters and slip_count stay in the top.

Test Plan:
- Reset, then continuous din_valid with RATIO=4 -> data_sof on beats 0,4,8…; frame_phase cycles 0..3; locked=0.
- 8 consecutive good verdicts (LOCK_GOOD=8) -> locked rises 1 cycle after the 8th; crc_gate follows the good verdicts only after lock.
- Start in HUNT with 1 bad verdict -> slip_pulse once, slip_count=1. The next data_sof arrives 5 beats after the previous one. The next 2 verdicts (BLANK_FRAMES=2) are ignored, even if bad.
- Locked, then bad,bad,good,bad,bad,bad,bad -> lock is held through the good; it drops after the 4th consecutive bad, and one slip is issued.
- VERIFY with 5 goods then 1 bad -> return to HUNT with one slip; the next lock needs a fresh 8 goods.
- Assert rst mid-VERIFY with din_valid held high -> next cycle: frame_phase=0, locked=0, slip_count=0, data_sof asserted on the first beat.
